// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and sequencer controls between the
// stopwatch front panel and the time-counter / display logic.
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_lap;
    logic       run_en;
    logic       clr;
    logic       lap_load;
    logic       disp_sel;
    logic [1:0] state;

    modport master (
        output btn_start, btn_lap,
        input  run_en, clr, lap_load, disp_sel, state
    );

    modport slave (
        input  btn_start, btn_lap,
        output run_en, clr, lap_load, disp_sel, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button sequencer: sync, debounce, long-press
// detection and the IDLE/RUN/PAUSE/LAP state machine.
module stopwatch_ctrl #(
    parameter int DB_CYCLES  = 20,
    parameter int LONG_PRESS = 1000
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int LW = (LONG_PRESS > 2) ? $clog2(LONG_PRESS) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
    localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS - 1);
    localparam logic [LW-1:0] LP_FIRE = LW'(LONG_PRESS - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    // bit 0 = start button, bit 1 = lap button
    logic [1:0]    w_raw;
    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_db;
    logic [1:0]    w_db_nxt;
    logic [1:0]    r_press;
    logic [DW-1:0] r_dcnt [2];
    logic [LW-1:0] r_lcnt;
    logic          r_long;

    state_t        r_state;
    state_t        w_nxt;
    logic          w_clr;
    logic          w_ll;
    logic          r_run;
    logic          r_disp;
    logic          r_clr;
    logic          r_ll;

    assign w_raw = {bus.btn_lap, bus.btn_start};

    // Debounced level after this edge: flips once the synced level has disagreed long enough
    always_comb begin
        w_db_nxt = r_db;
        for (int i = 0; i < 2; i++) begin
            if (r_s2[i] != r_db[i] && r_dcnt[i] == DB_LAST) begin
                w_db_nxt[i] = r_s2[i];
            end
        end
    end

    // Synchronisers, debounce counters and press-event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_db     <= '0;
            r_press  <= '0;
            r_dcnt[0] <= '0;
            r_dcnt[1] <= '0;
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_db    <= w_db_nxt;
            r_press <= w_db_nxt & ~r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_db[i] || r_dcnt[i] == DB_LAST) begin
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Long-press timer on debounced start; saturates so it fires once per hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lcnt <= '0;
            r_long <= 1'b0;
        end else begin
            if (!r_db[0]) begin
                r_lcnt <= '0;
            end else if (r_lcnt != LP_LAST) begin
                r_lcnt <= r_lcnt + 1'b1;
            end
            r_long <= r_db[0] & w_db_nxt[0] & (r_lcnt == LP_FIRE);
        end
    end

    // Next state with priority long > start > lap; losers are dropped
    always_comb begin
        w_nxt = r_state;
        w_clr = 1'b0;
        w_ll  = 1'b0;
        if (r_long) begin
            w_nxt = IDLE;
            w_clr = 1'b1;
        end else if (r_press[0]) begin
            unique case (r_state)
                IDLE:  w_nxt = RUN;
                RUN:   w_nxt = PAUSE;
                PAUSE: w_nxt = RUN;
                LAP:   w_nxt = PAUSE;
            endcase
        end else if (r_press[1]) begin
            unique case (r_state)
                IDLE:  w_nxt = IDLE;
                RUN: begin
                    w_nxt = LAP;
                    w_ll  = 1'b1;
                end
                PAUSE: begin
                    w_nxt = IDLE;
                    w_clr = 1'b1;
                end
                LAP:   w_nxt = RUN;
            endcase
        end
    end

    // State register with registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
            r_disp  <= 1'b0;
            r_clr   <= 1'b0;
            r_ll    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_run   <= (w_nxt == RUN) || (w_nxt == LAP);
            r_disp  <= (w_nxt == LAP);
            r_clr   <= w_clr;
            r_ll    <= w_ll;
        end
    end

    assign bus.state    = r_state;
    assign bus.run_en   = r_run;
    assign bus.disp_sel = r_disp;
    assign bus.clr      = r_clr;
    assign bus.lap_load = r_ll;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl against a
// sample-window / run-length behavioural model.
module tb_stopwatch_ctrl;
    localparam int DB = 4;
    localparam int LP = 16;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.DB_CYCLES(DB), .LONG_PRESS(LP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    bit         hs[$];
    bit         hl[$];
    bit         m_dbs, m_dbl;
    int         m_hlen;
    bit         e_s, e_l, e_g;
    logic [1:0] m_st;
    bit         m_clr, m_ll;

    task automatic model_reset();
        hs = {};
        hl = {};
        for (int j = 0; j < DB + 1; j++) begin
            hs.push_back(1'b0);
            hl.push_back(1'b0);
        end
        m_dbs = 0; m_dbl = 0; m_hlen = 0;
        e_s = 0; e_l = 0; e_g = 0;
        m_st = S_IDLE; m_clr = 0; m_ll = 0;
    endtask

    // one clock edge: FSM reacts to events seen on the previous edge
    task automatic model_edge(input bit s, input bit l);
        bit as, al;
        int n;
        m_clr = 0;
        m_ll  = 0;
        if (e_g) begin
            m_st  = S_IDLE;
            m_clr = 1;
        end else if (e_s) begin
            m_st = (m_st == S_RUN || m_st == S_LAP) ? S_PAUSE : S_RUN;
        end else if (e_l) begin
            case (m_st)
                S_RUN:   begin m_st = S_LAP; m_ll = 1; end
                S_LAP:   m_st = S_RUN;
                S_PAUSE: begin m_st = S_IDLE; m_clr = 1; end
                default: ;
            endcase
        end
        hs.push_back(s);
        hl.push_back(l);
        if (hs.size() > DB + 2) begin
            void'(hs.pop_front());
            void'(hl.pop_front());
        end
        n  = hs.size();
        as = 1;
        al = 1;
        // raw samples two..DB+1 edges old all disagree -> accept
        for (int j = 2; j <= DB + 1; j++) begin
            if (hs[n-1-j] == m_dbs) as = 0;
            if (hl[n-1-j] == m_dbl) al = 0;
        end
        e_s = as && !m_dbs;
        e_l = al && !m_dbl;
        if (as) m_dbs = !m_dbs;
        if (al) m_dbl = !m_dbl;
        m_hlen = m_dbs ? m_hlen + 1 : 0;
        e_g = (m_hlen == LP);
    endtask

    function automatic logic [5:0] obs();
        return {bus.state, bus.run_en, bus.disp_sel, bus.clr, bus.lap_load};
    endfunction

    function automatic logic [5:0] expv();
        logic re, ds;
        re = (m_st == S_RUN) || (m_st == S_LAP);
        ds = (m_st == S_LAP);
        return {m_st, re, ds, m_clr, m_ll};
    endfunction

    task automatic step(input bit s, input bit l);
        bus.btn_start = s;
        bus.btn_lap   = l;
        @(posedge clk);
        model_edge(s, l);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (obs() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset got %b exp %b", obs(), 6'b0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_start_press();
        int first = -1;
        for (int i = 1; i <= 25; i++) begin
            step(i <= 10, 1'b0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL start_press c%0d got %b exp %b", i, obs(), expv());
            end
            if (first < 0 && bus.state == S_RUN) first = i;
        end
        n_tests++;
        if (first != 7 || bus.state !== S_RUN || bus.run_en !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency got c%0d st %b exp c7 st 01", first, bus.state);
        end
    endtask

    task automatic test_lap_bounce();
        int first = -1;
        int nll = 0;
        bit l;
        for (int i = 1; i <= 24; i++) begin
            l = (i <= 4) ? ((i % 2) == 1) : (i <= 12);
            step(1'b0, l);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL lap_bounce c%0d got %b exp %b", i, obs(), expv());
            end
            if (first < 0 && bus.state == S_LAP) first = i;
            if (bus.lap_load) nll++;
        end
        n_tests++;
        if (first != 11 || nll != 1 || bus.disp_sel !== 1'b1 || bus.run_en !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_capture got c%0d ll%0d exp c11 ll1", first, nll);
        end
    endtask

    task automatic test_pause_clear();
        int nclr = 0;
        for (int i = 1; i <= 36; i++) begin
            step(i <= 8, (i > 18) && (i <= 26));
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL pause_clear c%0d got %b exp %b", i, obs(), expv());
            end
            if (i == 18 && (bus.state !== S_PAUSE || bus.run_en !== 1'b0 || bus.disp_sel !== 1'b0)) begin
                n_fail++;
                $display("FAIL pause_from_lap got %b exp 10/0/0", obs());
            end
            if (i == 18) n_tests++;
            if (bus.clr) nclr++;
        end
        n_tests++;
        if (nclr != 1 || bus.state !== S_IDLE) begin
            n_fail++;
            $display("FAIL clear_from_pause got clr%0d st %b exp clr1 st 00", nclr, bus.state);
        end
    endtask

    task automatic test_long_press();
        int nclr = 0;
        int at = -1;
        bit saw_pause = 0;
        for (int i = 1; i <= 18; i++) step(i <= 8, 1'b0);
        for (int i = 1; i <= 42; i++) begin
            step(i <= 30, 1'b0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL long_press c%0d got %b exp %b", i, obs(), expv());
            end
            if (bus.state == S_PAUSE) saw_pause = 1;
            if (bus.clr) begin
                nclr++;
                at = i;
            end
        end
        n_tests++;
        if (!saw_pause || nclr != 1 || at != 22 || bus.state !== S_IDLE) begin
            n_fail++;
            $display("FAIL long_clear got clr%0d at c%0d pause%0d exp clr1 at c22 pause1", nclr, at, saw_pause);
        end
    endtask

    task automatic test_simultaneous();
        int nll = 0;
        for (int i = 1; i <= 18; i++) step(i <= 8, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            step(i <= 8, i <= 8);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL simultaneous c%0d got %b exp %b", i, obs(), expv());
            end
            if (bus.lap_load) nll++;
        end
        n_tests++;
        if (bus.state !== S_PAUSE || nll != 0) begin
            n_fail++;
            $display("FAIL start_beats_lap got st %b ll%0d exp st 10 ll0", bus.state, nll);
        end
    endtask

    task automatic test_async_reset();
        int first = -1;
        for (int i = 1; i <= 36; i++) step(i <= 8, (i > 18) && (i <= 26));
        n_tests++;
        if (bus.state !== S_LAP) begin
            n_fail++;
            $display("FAIL reach_lap got %b exp 11", bus.state);
        end
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (obs() !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset got %b exp %b", obs(), 6'b0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 22; i++) begin
            step(i <= 12, 1'b0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL post_reset c%0d got %b exp %b", i, obs(), expv());
            end
            if (first < 0 && bus.state == S_RUN) first = i;
        end
        n_tests++;
        if (first != 7) begin
            n_fail++;
            $display("FAIL post_reset_latency got c%0d exp c7", first);
        end
    endtask

    task automatic test_random();
        bit s = 0, l = 0;
        int rs = 3, rl = 5;
        for (int i = 1; i <= 900; i++) begin
            if (--rs <= 0) begin
                s  = !s;
                rs = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 30) : $urandom_range(1, 8);
            end
            if (--rl <= 0) begin
                l  = !l;
                rl = $urandom_range(1, 10);
            end
            step(s, l);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random c%0d got %b exp %b", i, obs(), expv());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.btn_start = 1'b0;
        bus.btn_lap   = 1'b0;
        model_reset();
        test_reset();
        test_start_press();
        test_lap_bounce();
        test_pause_clear();
        test_long_press();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
